avl_mm_arbiter_2x1: RTL
=======================

AVL_MM_ARBITER_2X1 -- requirements
Module: avl_mm_arbiter_2x1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of every address port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of every data port.
REQ-003 SHALL have parameter MAX_PENDING, default 4, depth of the read-routing FIFO (2..16).
REQ-004 Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- mN_address  in  ADDR_WIDTH  requester N address (N = 0, 1)
- mN_write / mN_read  in  1  requester N command strobes
- mN_burstcount  in  12  requester N burst length
- mN_beginbursttransfer  in  1  requester N burst start
- mN_lock  in  1  requester N holds grant
- mN_writedata  in  DATA_WIDTH  requester N write data
- mN_readdata  out  DATA_WIDTH  read data to requester N
- mN_readdatavalid  out  1  read beat valid to requester N
- mN_waitrequest_n  out  1  command accepted from requester N
- mN_response  out  2  response to requester N
- avl_address  out  ADDR_WIDTH  to slave
- avl_write / avl_read  out  1  to slave
- avl_burstcount  out  12  to slave
- avl_beginbursttransfer  out  1  to slave
- avl_lock  out  1  to slave
- avl_writedata  out  DATA_WIDTH  to slave
- avl_readdata  in  DATA_WIDTH  from slave
- avl_readdatavalid  in  1  from slave
- avl_waitrequest_n  in  1  slave ready
- avl_response  in  2  from slave

Function
REQ-005 SHALL implement a three-state FSM: IDLE, GRANT, WBURST.
REQ-006 IDLE: on any mN_read|mN_write, SHALL register the grant and move to GRANT at the next edge; no command reaches the slave in IDLE.
REQ-007 Arbitration SHALL be round-robin: on a simultaneous request, grant goes to the requester not granted last; a lone requester is always granted.
REQ-008 GRANT: the granted requester's command signals SHALL drive the avl_* outputs combinationally; the non-granted requester's outputs SHALL be forced to 0 and its mN_waitrequest_n held at 0.
REQ-009 Granted mN_waitrequest_n SHALL equal avl_waitrequest_n, except that it is 0 when a read is presented and the FIFO is full; avl_read SHALL be suppressed (0) in that case.
REQ-010 Accepted read (avl_read & avl_waitrequest_n): SHALL push {id, burstcount} into the FIFO; burstcount 0 SHALL be treated as 1.
REQ-011 Accepted write with burstcount > 1: SHALL load the remaining-beat counter with burstcount-1 and enter WBURST.
REQ-012 WBURST: the grant SHALL be held; each accepted write beat decrements the counter; when it reaches 0, SHALL exit as in REQ-013.
REQ-013 After an accepted single command or final write beat: if the owner's mN_lock=1, SHALL stay in GRANT; otherwise SHALL return to IDLE.
REQ-014 avl_lock SHALL equal the owner's mN_lock while in GRANT/WBURST, and 0 in IDLE.
REQ-015 Read return: avl_readdatavalid SHALL be routed to the requester at the FIFO head with avl_readdata and avl_response, zero latency; the other requester sees readdatavalid=0.
REQ-016 The head beat count SHALL decrement per valid beat; on reaching 0 the entry is popped. Push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-017 avl_readdatavalid with an empty FIFO SHALL be dropped; a sticky internal error flag SHALL be set, cleared only by reset.
REQ-018 mN_response SHALL be 2'b00 whenever mN_readdatavalid=0.
REQ-019 Read routing SHALL continue independently of command arbitration (reads outstanding from both requesters allowed).

Reset
REQ-020 With reset_n=0 at a clock edge, SHALL set state IDLE, the last-grant pointer to 1 (so requester 0 wins first), the FIFO empty, counters 0, and the error flag 0.
REQ-021 During and after reset, all avl_* command outputs, mN_waitrequest_n, mN_readdatavalid, and mN_response SHALL be 0 until a grant is issued.
REQ-022 Reset mid-burst or with reads outstanding SHALL abandon all state; late slave beats fall under REQ-017.

Verification
REQ-023 Single write: m0 write, address 0xA, data 0x1234, burstcount 1 -> m0_waitrequest_n=1 one cycle after the request, avl_address=0xA, FSM back to IDLE.
REQ-024 Contention: m0 and m1 read in the same cycle after reset -> m0 served first; on their next simultaneous request, m1 wins.
REQ-025 Write burst: m1 burstcount 4, slave ready -> 4 accepted beats with m0 blocked throughout, then IDLE.
REQ-026 Read routing: m0 reads burstcount 2, then m1 reads 1; slave returns 0xB0, 0xB1, 0xC0 -> m0 gets 0xB0 and 0xB1, then m1 gets 0xC0.
REQ-027 FIFO full: MAX_PENDING=4, 4 reads outstanding, 5th read -> waitrequest_n=0 and avl_read=0 until a pop, then accepted.
REQ-028 Lock: m0_lock=1 across 3 writes while m1 requests -> m1 not granted until the cycle after m0_lock drops.

Source files
------------

// File: rtl/avl_mm_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// avl_mm_arbiter_2x1
//
// Two-requester Avalon-MM arbiter in front of a single slave.
//
// Command path: a three-state FSM (IDLE / GRANT / WBURST) picks one owner with
// round-robin fairness. While an owner holds the grant, its command signals
// drive the slave combinationally. Write bursts keep the grant until the last
// beat. mN_lock keeps the grant across commands.
//
// Read return path: every accepted read pushes {requester id, beat count} into
// a small routing FIFO. Returning beats are steered to the requester at the
// FIFO head with zero latency. This is independent of the command FSM, so both
// requesters may have reads outstanding at once.
//
// Parameters
//   ADDR_WIDTH   address width of every address port
//   DATA_WIDTH   data width of every data port
//   MAX_PENDING  read-routing FIFO depth (2..16)
//
// Ports
//   clk, reset_n                          clock, synchronous active-low reset
//   mN_address/write/read/burstcount/
//   beginbursttransfer/lock/writedata     requester N command inputs
//   mN_readdata/readdatavalid/response    read return to requester N
//   mN_waitrequest_n                      command accepted from requester N
//   avl_address/write/read/burstcount/
//   beginbursttransfer/lock/writedata     command outputs to the slave
//   avl_readdata/readdatavalid/response   read return from the slave
//   avl_waitrequest_n                     slave ready
// -----------------------------------------------------------------------------
module avl_mm_arbiter_2x1 #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  // requester 0
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_write,
  input  logic                  m0_read,
  input  logic [11:0]           m0_burstcount,
  input  logic                  m0_beginbursttransfer,
  input  logic                  m0_lock,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  output logic                  m0_waitrequest_n,
  output logic [1:0]            m0_response,

  // requester 1
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_write,
  input  logic                  m1_read,
  input  logic [11:0]           m1_burstcount,
  input  logic                  m1_beginbursttransfer,
  input  logic                  m1_lock,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  m1_waitrequest_n,
  output logic [1:0]            m1_response,

  // slave
  output logic [ADDR_WIDTH-1:0] avl_address,
  output logic                  avl_write,
  output logic                  avl_read,
  output logic [11:0]           avl_burstcount,
  output logic                  avl_beginbursttransfer,
  output logic                  avl_lock,
  output logic [DATA_WIDTH-1:0] avl_writedata,
  input  logic [DATA_WIDTH-1:0] avl_readdata,
  input  logic                  avl_readdatavalid,
  input  logic                  avl_waitrequest_n,
  input  logic [1:0]            avl_response
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PENDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_WBURST = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic        owner_q;      // requester currently holding the grant
  logic        last_q;       // requester granted most recently
  logic [11:0] beats_q;      // remaining write-burst beats after the first

  logic                  fid_q  [MAX_PENDING];
  logic [11:0]           fcnt_q [MAX_PENDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  error_q;  // sticky: read beat arrived with nothing outstanding

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic req0, req1, win_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // On contention the requester not granted last wins; otherwise the lone one.
  assign win_id = (req0 && req1) ? ~last_q : req1;

  // ---------------------------------------------------------------------------
  // Owner command mux
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] own_address;
  logic                  own_write, own_read, own_bbt, own_lock;
  logic [11:0]           own_burst;
  logic [DATA_WIDTH-1:0] own_writedata;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    own_address   = m0_address;
    own_write     = m0_write;
    own_read      = m0_read;
    own_burst     = m0_burstcount;
    own_bbt       = m0_beginbursttransfer;
    own_lock      = m0_lock;
    own_writedata = m0_writedata;
    if (owner_q) begin
      own_address   = m1_address;
      own_write     = m1_write;
      own_read      = m1_read;
      own_burst     = m1_burstcount;
      own_bbt       = m1_beginbursttransfer;
      own_lock      = m1_lock;
      own_writedata = m1_writedata;
    end
  end

  // ---------------------------------------------------------------------------
  // Command outputs
  // ---------------------------------------------------------------------------
  logic granted, fifo_full, fifo_empty, read_block, own_wrn;
  logic rd_acc, wr_acc;

  // Gating with reset_n keeps every output quiet while reset is held, even
  // before the first reset edge has cleared the state.
  assign granted    = reset_n && (state_q != ST_IDLE);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // A read cannot be issued when there is no room to remember where it goes.
  assign read_block = own_read & fifo_full;
  assign own_wrn    = granted & avl_waitrequest_n & ~read_block;

  always_comb begin
    avl_address            = '0;
    avl_write              = 1'b0;
    avl_read               = 1'b0;
    avl_burstcount         = '0;
    avl_beginbursttransfer = 1'b0;
    avl_lock               = 1'b0;
    avl_writedata          = '0;
    if (granted) begin
      avl_address            = own_address;
      avl_write              = own_write;
      avl_read               = own_read & ~fifo_full;
      avl_burstcount         = own_burst;
      avl_beginbursttransfer = own_bbt;
      avl_lock               = own_lock;
      avl_writedata          = own_writedata;
    end
  end

  assign m0_waitrequest_n = own_wrn & ~owner_q;
  assign m1_waitrequest_n = own_wrn &  owner_q;

  assign rd_acc = avl_read  & avl_waitrequest_n;
  assign wr_acc = avl_write & avl_waitrequest_n;

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;          // requester 0 wins the first contention
      beats_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner_q <= win_id;
            last_q  <= win_id;
            state_q <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (wr_acc && (own_burst > 12'd1)) begin
            beats_q <= own_burst - 12'd1;
            state_q <= ST_WBURST;
          end else if (rd_acc || wr_acc) begin
            if (!own_lock) state_q <= ST_IDLE;
          end else if (!own_lock && !own_read && !own_write) begin
            // Owner went quiet without holding a lock: release the grant.
            state_q <= ST_IDLE;
          end
        end

        ST_WBURST: begin
          if (wr_acc) begin
            beats_q <= beats_q - 12'd1;
            if (beats_q == 12'd1) state_q <= own_lock ? ST_GRANT : ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read-routing FIFO
  // ---------------------------------------------------------------------------
  logic        push, beat, pop, head_id;
  logic [11:0] push_cnt;

  assign push     = rd_acc;
  // A zero burstcount is a single-beat read.
  assign push_cnt = (own_burst == 12'd0) ? 12'd1 : own_burst;
  assign head_id  = fid_q[rd_ptr_q];
  // Beats with nothing outstanding are dropped.
  assign beat     = reset_n & avl_readdatavalid & ~fifo_empty;
  assign pop      = beat & (fcnt_q[rd_ptr_q] == 12'd1);

  // NOTE: the FIFO storage carries no reset; only pointers and occupancy do,
  // and an entry is never read before it has been written.
  // Push and the head update never hit the same slot: a shared slot means the
  // FIFO is empty (no beat) or full (no push).
  always_ff @(posedge clk) begin
    if (push) begin
      fid_q[wr_ptr_q]  <= owner_q;
      fcnt_q[wr_ptr_q] <= push_cnt;
    end
    if (beat && !pop) fcnt_q[rd_ptr_q] <= fcnt_q[rd_ptr_q] - 12'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;     // idle, or push and pop cancel
      endcase
      if (avl_readdatavalid && fifo_empty) error_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return steering
  // ---------------------------------------------------------------------------
  assign m0_readdatavalid = beat & ~head_id;
  assign m1_readdatavalid = beat &  head_id;
  assign m0_readdata      = m0_readdatavalid ? avl_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? avl_readdata : '0;
  assign m0_response      = m0_readdatavalid ? avl_response : 2'b00;
  assign m1_response      = m1_readdatavalid ? avl_response : 2'b00;

endmodule
